// File: rtl/gpio_mailbox_pkg.sv
// Shared types and widths for the GPIO mailbox.
// Optional drop counter output is enabled by GPIO_MAILBOX_DROP_CNT_EN.
`timescale 1ns/1ps
package gpio_mailbox_pkg;
    localparam int GPIO_W     = 32;
    localparam int DROP_CNT_W = 8;

    typedef enum logic {IDLE, HOLD} mbox_state_t;

    // Width of a down-counter that must hold values 0..n-1 (never zero bits).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gpio_mailbox_fifo.sv
// Synchronous FIFO with a registered head word and valid flag (no fall-through).
`timescale 1ns/1ps
module gpio_mailbox_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d, count_rem;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             do_pop, wr_en;

    always_comb begin
        do_pop    = pop_i & valid_q;
        full_o    = (count_q == CW'(DEPTH));
        empty_o   = (count_q == '0);
        wr_en     = push_i & (~full_o | do_pop);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        count_rem = count_q - CW'(do_pop);
        count_d   = count_rem + CW'(wr_en);
        valid_d   = (count_d != '0);
        // Head register is preloaded with the next word; forward the incoming
        // word when it lands in an otherwise empty FIFO.
        head_d    = head_q;
        if (count_rem != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (wr_en) begin
            head_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/gpio_mailbox.sv
// Device-side GPIO partner: change-queued outbound FIFO and held inbound word.
// Define GPIO_MAILBOX_DROP_CNT_EN to add the saturating drop_cnt output.
`timescale 1ns/1ps
module gpio_mailbox
    import gpio_mailbox_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] cpu_gpio_out,
    output logic [GPIO_W-1:0] cpu_gpio_in,
    output logic [GPIO_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [GPIO_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear_ovf,
    output logic              overflow
`ifdef GPIO_MAILBOX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);
    localparam int HCW = cnt_w(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

    logic [GPIO_W-1:0] prev_out_q;
    logic              push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic              ovf_q, ovf_d;
    mbox_state_t       state_q, state_d;
    logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [GPIO_W-1:0] gpio_in_q, gpio_in_d;

    assign push = (cpu_gpio_out != prev_out_q);
    assign pop  = out_ready & ~fifo_empty;
    assign drop = push & fifo_full & ~pop;

    gpio_mailbox_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (GPIO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (cpu_gpio_out),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (out_data),
        .valid_o (out_valid)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gpio_in_d  = gpio_in_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    gpio_in_d  = in_data;
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_out_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            gpio_in_q  <= '0;
        end else begin
            prev_out_q <= cpu_gpio_out;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gpio_in_q  <= gpio_in_d;
        end
    end

    assign in_ready    = rst & (state_q == IDLE);
    assign cpu_gpio_in = gpio_in_q;
    assign overflow    = ovf_q;

`ifdef GPIO_MAILBOX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // A clear coinciding with a drop still records that one drop.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf) begin
            drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_gpio_mailbox.sv
// Self-checking bench for gpio_mailbox: queue/counter model plus directed literal checks.
`timescale 1ns/1ps
module tb_gpio_mailbox;
    localparam int DEPTH = 8;
    localparam int HOLD  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_gpio_out = '0;
    logic [31:0] cpu_gpio_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        clear_ovf = 1'b0;
    logic        overflow;
`ifdef GPIO_MAILBOX_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    always #5 clk = ~clk;

    gpio_mailbox #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_gpio_out (cpu_gpio_out),
        .cpu_gpio_in  (cpu_gpio_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clear_ovf    (clear_ovf),
        .overflow     (overflow)
`ifdef GPIO_MAILBOX_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Model state: words waiting for the consumer, last CPU word, sticky flag,
    // held inbound word, cycles of inbound back-pressure remaining.
    logic [31:0] m_q[$];
    logic [31:0] m_prev = '0;
    bit          m_ovf  = 1'b0;
    logic [31:0] m_gin  = '0;
    int          m_hold = 0;
    int          m_drops = 0;

    logic [31:0] rx[$];
    int          rx_cyc[$];
    int          acc_cyc[$];

    // Mid-cycle: compare outputs to the model, log handshakes, then advance the
    // model with this cycle's inputs.
    always @(negedge clk) begin : model
        bit pop, push, drop;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() > 0});
        if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
        chk("cpu_gpio_in", cpu_gpio_in, m_gin);
        chk("in_ready", {31'b0, in_ready}, {31'b0, (rst && m_hold == 0)});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef GPIO_MAILBOX_DROP_CNT_EN
        chk("drop_cnt", {24'b0, drop_cnt}, 32'(m_drops));
`endif
        if (rst && out_valid && out_ready) begin
            rx.push_back(out_data);
            rx_cyc.push_back(cyc_n);
        end
        if (rst && in_valid && in_ready) acc_cyc.push_back(cyc_n);

        if (!rst) begin
            m_q.delete();
            m_prev  = '0;
            m_ovf   = 1'b0;
            m_gin   = '0;
            m_hold  = 0;
            m_drops = 0;
        end else begin
            pop  = (m_q.size() > 0) && out_ready;
            push = (cpu_gpio_out != m_prev);
            drop = push && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !drop) m_q.push_back(cpu_gpio_out);
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
            if (clear_ovf) begin
                m_ovf   = drop;
                m_drops = drop ? 1 : 0;
            end
            m_prev = cpu_gpio_out;
            if (m_hold == 0 && in_valid) begin
                m_gin  = in_data;
                m_hold = HOLD;
            end else if (m_hold > 0) begin
                m_hold--;
            end
        end
        cyc_n++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek();
        #1;
    endtask

    initial begin
        // Reset, release, idle
        step(3);
        rst = 1'b1;
        peek();
        chk("in_ready_after_release", {31'b0, in_ready}, 32'd1);
        step(20);
        peek();
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
        chk("idle_gpio_in", cpu_gpio_in, 32'd0);

        // Two changes, consumer always ready
        rx.delete();
        out_ready    = 1'b1;
        cpu_gpio_out = 32'h0000_00A5;
        step(1);
        peek();
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_data", out_data, 32'h0000_00A5);
        step(2);
        cpu_gpio_out = 32'h0000_005A;
        peek();
        chk("t3_valid", {31'b0, out_valid}, 32'd0);
        step(1);
        peek();
        chk("t4_valid", {31'b0, out_valid}, 32'd1);
        chk("t4_data", out_data, 32'h0000_005A);
        step(5);
        chk("two_words_count", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            chk("two_words_w0", rx[0], 32'h0000_00A5);
            chk("two_words_w1", rx[1], 32'h0000_005A);
        end

        // Ten changes into an 8-deep FIFO with a stalled consumer
        out_ready = 1'b0;
        for (int v = 1; v <= 10; v++) begin
            cpu_gpio_out = 32'(v);
            step(1);
        end
        peek();
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        chk("ovf_head", out_data, 32'd1);
        rx.delete();
        rx_cyc.delete();
        out_ready = 1'b1;
        step(12);
        out_ready = 1'b0;
        chk("ovf_drain_count", 32'(rx.size()), 32'd8);
        if (rx.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("ovf_drain_word", rx[i], 32'(i + 1));
            chk("ovf_no_bubble", 32'(rx_cyc[7] - rx_cyc[0]), 32'd7);
        end
        clear_ovf = 1'b1;
        step(1);
        clear_ovf = 1'b0;
        peek();
        chk("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Full FIFO: push and pop in the same cycle must not drop
        rx.delete();
        for (int i = 0; i < 8; i++) begin
            cpu_gpio_out = 32'h100 + 32'(i);
            step(1);
        end
        peek();
        chk("full_no_ovf", {31'b0, overflow}, 32'd0);
        cpu_gpio_out = 32'h200;
        out_ready    = 1'b1;
        step(1);
        out_ready = 1'b0;
        peek();
        chk("pushpop_no_ovf", {31'b0, overflow}, 32'd0);
        chk("pushpop_head", out_data, 32'h101);
        step(2);
        out_ready = 1'b1;
        step(12);
        out_ready = 1'b0;
        chk("pushpop_total", 32'(rx.size()), 32'd9);
        if (rx.size() == 9) begin
            chk("pushpop_first", rx[0], 32'h100);
            chk("pushpop_last", rx[8], 32'h200);
        end

        // Inbound: producer holds valid, two words
        acc_cyc.delete();
        in_data  = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        for (int k = 0; k < 30 && acc_cyc.size() < 2; k++) begin
            if (acc_cyc.size() == 1) in_data = 32'h1234_5678;
            step(1);
        end
        in_valid = 1'b0;
        chk("in_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() == 2) chk("in_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
        peek();
        chk("in_word2", cpu_gpio_in, 32'h1234_5678);
        step(6);

        // Reset during HOLD with three words queued
        for (int i = 0; i < 3; i++) begin
            cpu_gpio_out = 32'h31 + 32'(i);
            step(1);
        end
        in_data  = 32'hCAFE_0001;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(2);
        rst          = 1'b0;
        cpu_gpio_out = '0;
        step(1);
        rst = 1'b1;
        peek();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_gpio_in", cpu_gpio_in, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rx.delete();
        out_ready = 1'b1;
        step(10);
        out_ready = 1'b0;
        chk("rst_no_stale", 32'(rx.size()), 32'd0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gpio_mailbox.md
Name: gpio_mailbox

Overview:
- Device-side partner of the CPU's GPIO port.
- Consumes the CPU's `gpio_out` and drives its `gpio_in`.
- Outbound path: every change of the CPU output word is queued in a FIFO and handed to an external consumer (host, display controller) with valid/ready.
- Inbound path: accepts words from an external producer with valid/ready and holds each on `gpio_in` for a guaranteed minimum number of cycles, so CPU GPIO-read instructions can sample it.

Parameters:
- DEPTH, 8, outbound FIFO entries; power of two, ≥2.
- HOLD_CYCLES, 4, minimum cycles an accepted inbound word is held before the next word is accepted; ≥1.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low (asserted when 0).
- cpu_gpio_out  input  32  CPU `gpio_out` word.
- cpu_gpio_in  output  32  word presented to CPU `gpio_in`.
- out_data  output  32  head-of-FIFO word.
- out_valid  output  1  `out_data` valid.
- out_ready  input  1  consumer accepts `out_data`.
- in_data  input  32  producer word.
- in_valid  input  1  producer word valid.
- in_ready  output  1  block can accept `in_data`.
- clear_ovf  input  1  clears the `overflow` flag.
- overflow  output  1  sticky: at least one outbound word was dropped.

Behaviour:
- Reset (rst==0 at posedge):
  - `prev_out`=0, FIFO empty (rd/wr pointers 0, count 0).
  - `out_valid`=0, `out_data`=0, `cpu_gpio_in`=0, `overflow`=0.
  - Inbound state=IDLE, `hold_cnt`=0.
  - `in_ready`=0 while rst is low; 1 from the first cycle after release.
  - Reset mid-operation discards FIFO contents and any hold in progress. No handshake completes in a reset cycle.
- Change detect:
  - `prev_out` registers `cpu_gpio_out` every cycle.
  - `push` = (`cpu_gpio_out` != `prev_out`), combinational.
  - Both the CPU's `gpio_out` and `prev_out` reset to 0, so reset never produces a spurious push.
- Outbound FIFO:
  - Write on the posedge ending a push cycle.
  - `out_data` and `out_valid` are registered; no fall-through. A word pushed in cycle t into an empty FIFO shows `out_valid`=1 in t+1.
  - `pop` = `out_valid` & `out_ready`. The head advances on that edge; the next word, if any, appears the following cycle with no bubble.
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
  - Full, push, no pop: new word dropped, FIFO unchanged, `overflow`<=1.
  - Full, push and pop together: both occur, count unchanged, no drop.
  - Empty and pop is impossible because `out_valid`=0.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
  - `clear_ovf` in the same cycle as a new drop: set wins, `overflow` stays 1.
- Inbound FSM:
  - IDLE:
    - `in_ready`=1.
    - If `in_valid`: `cpu_gpio_in`<=`in_data`, `hold_cnt`<=HOLD_CYCLES-1, go to HOLD.
  - HOLD:
    - `in_ready`=0.
    - If `hold_cnt`==0, go to IDLE; else decrement.
  - `in_ready` is therefore low for exactly HOLD_CYCLES cycles after each accept, so back-to-back producer words are spaced HOLD_CYCLES+1 cycles apart.
  - `cpu_gpio_in` keeps the last accepted word indefinitely.
  - HOLD_CYCLES=1: one cycle of HOLD.
- Outbound and inbound paths are fully independent. Simultaneous activity on both has no interaction.

Optional Feature:
- Macro: GPIO_MAILBOX_DROP_CNT_EN.
- Defined:
  - Extra output port `drop_cnt` [7:0].
  - Increments on each dropped word, saturating at 255.
  - Cleared by `clear_ovf`; a clear in the same cycle as a drop leaves `drop_cnt`=1.
  - Reset value 0.
- Undefined: port absent; only the sticky `overflow` flag exists. All other behaviour is identical.

Decomposition:
- Package gpio_mailbox_pkg:
  - GPIO_W=32.
  - typedef enum logic {IDLE, HOLD} mbox_state_t.
  - DROP_CNT_W=8.
- Sub-module gpio_mailbox_fifo:
  - Synchronous FIFO parameterised by DEPTH and width.
  - push/pop in; full, empty, registered head data, valid out.
- The top level holds change detection, overflow logic and the inbound FSM.

Test Plan:
- Reset then idle, `cpu_gpio_out`=0 for 20 cycles → `out_valid` stays 0, `cpu_gpio_in`=0, `in_ready`=1 from the cycle after release.
- `cpu_gpio_out`: 0→0x0000_00A5 at t, →0x0000_005A at t+3, `out_ready`=1 → `out_valid` at t+1 with 0xA5, at t+4 with 0x5A; exactly two words.
- `out_ready`=0, `cpu_gpio_out` changes 10 times with DEPTH=8 (values 1..10) → first 8 words retained, `overflow`=1. Then `out_ready`=1 → words 1..8 in order, no bubble. `clear_ovf` pulse → `overflow`=0.
- FIFO full, one more push in the same cycle as a pop → no drop, `overflow` stays 0, count stays 8.
- `in_valid` held high with `in_data`=0xDEAD_BEEF then 0x1234_5678, HOLD_CYCLES=4 → accepts 5 cycles apart. `cpu_gpio_in` changes only at accepts. `in_ready` is low 4 cycles after each accept.
- rst low during HOLD with 3 words queued → next cycle `out_valid`=0, `cpu_gpio_in`=0, FSM IDLE. After release, `in_ready`=1 and no stale words emerge.
